// File: rtl/trace_mem_ctrl.sv
// Trace buffer memory controller: ring store for the Tracer with
// trigger/post-trigger freeze in trace mode, plain FIFO in stream modes.
package trace_mem_pkg;
   typedef enum logic [1:0] {
      trace_mode    = 2'd0,
      w_stream_mode = 2'd1,
      r_stream_mode = 2'd2
   } trg_mode_t;
endpackage

module trace_mem_ctrl
   import trace_mem_pkg::*;
#(
   parameter int TRB_WIDTH = 32,
   parameter int TRB_DEPTH = 64,
   localparam int AW = $clog2(TRB_DEPTH),
   localparam int PW = $clog2(TRB_WIDTH),
   localparam int CW = AW + 1
) (
   input  logic                 FPGA_CLK_I,
   input  logic                 RST_I,
   input  trg_mode_t            MODE_I,
   input  logic [AW-1:0]        POST_WORDS_I,
   input  logic                 STORE_I,
   input  logic [TRB_WIDTH-1:0] DATA_I,
   output logic                 STORE_PERM_O,
   input  logic                 LOAD_REQUEST_I,
   output logic                 LOAD_GRANT_O,
   output logic [TRB_WIDTH-1:0] DATA_O,
   input  logic                 TRG_EVENT_I,
   input  logic [PW-1:0]        EVENT_POS_I,
   output logic                 TRG_DELAYED_O,
   output logic [AW-1:0]        TRG_ADDR_O,
   output logic [PW-1:0]        EVENT_POS_O,
   output logic [CW-1:0]        COUNT_O
);

   typedef enum logic [1:0] {
      ST_STREAM,
      ST_ARMED,
      ST_POST,
      ST_FROZEN
   } state_t;

   state_t state_q, state_d;

   logic [TRB_WIDTH-1:0] mem_q [TRB_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        count_q;
   logic [CW-1:0]        pc_q;
   logic                 grant_q;
   logic [TRB_WIDTH-1:0] data_q;
   logic [AW-1:0]        trg_addr_q;
   logic [PW-1:0]        evt_pos_q;
   logic                 trg_dly_q;

   logic          store_perm;
   logic          load_ok;
   logic          store_acc;
   logic          full;
   logic          overwrite;
   logic          inc;
   logic          grant_d;
   logic          trg_hit;
   logic          in_post;
   logic [CW-1:0] pc_d;
   logic          freeze;

   assign full      = (count_q == CW'(TRB_DEPTH));
   assign store_acc = STORE_I & store_perm;
   assign overwrite = store_acc & full;
   assign inc       = store_acc & ~full;
   assign grant_d   = LOAD_REQUEST_I & (count_q != '0)
                    & load_ok & ~grant_q;
   assign trg_hit   = (state_q == ST_ARMED) & TRG_EVENT_I;
   assign in_post   = (state_q == ST_POST);

   // The trigger cycle restarts pc, and a store in that same cycle is the trigger word
   assign pc_d   = (trg_hit ? '0 : pc_q) + CW'(store_acc);
   assign freeze = store_acc & (trg_hit | in_post)
                 & (pc_d == CW'(POST_WORDS_I) + CW'(1));

   always_ff @(posedge FPGA_CLK_I) begin
      if (!RST_I) begin
         state_q <= (MODE_I == trace_mode) ? ST_ARMED : ST_STREAM;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_ARMED: begin
            if (trg_hit) state_d = freeze ? ST_FROZEN : ST_POST;
         end
         ST_POST: begin
            if (freeze) state_d = ST_FROZEN;
         end
         default: ;
      endcase
   end

   always_comb begin
      store_perm = 1'b0;
      load_ok    = 1'b0;
      unique case (state_q)
         ST_STREAM: begin
            store_perm = ~full;
            load_ok    = 1'b1;
         end
         ST_ARMED,
         ST_POST: begin
            store_perm = 1'b1;
         end
         ST_FROZEN: begin
            load_ok = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge FPGA_CLK_I) begin
      if (store_acc) mem_q[wr_ptr_q] <= DATA_I;
   end

   always_ff @(posedge FPGA_CLK_I) begin
      if (!RST_I) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pc_q       <= '0;
         grant_q    <= 1'b0;
         data_q     <= '0;
         trg_addr_q <= '0;
         evt_pos_q  <= '0;
         trg_dly_q  <= 1'b0;
      end else begin
         grant_q <= grant_d;
         if (grant_d) data_q <= mem_q[rd_ptr_q];
         if (store_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
         // Loads are never allowed while overwriting, so one increment suffices
         if (grant_d | overwrite) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({inc, grant_d})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: ;
         endcase
         if (trg_hit) begin
            trg_addr_q <= wr_ptr_q;
            evt_pos_q  <= EVENT_POS_I;
         end
         if (trg_hit | in_post) pc_q <= pc_d;
         if (freeze) trg_dly_q <= 1'b1;
      end
   end

   assign STORE_PERM_O  = store_perm;
   assign LOAD_GRANT_O  = grant_q;
   assign DATA_O        = data_q;
   assign TRG_DELAYED_O = trg_dly_q;
   assign TRG_ADDR_O    = trg_addr_q;
   assign EVENT_POS_O   = evt_pos_q;
   assign COUNT_O       = count_q;

endmodule

// File: tb/tb_trace_mem_ctrl.sv
// Scoreboard bench for trace_mem_ctrl: stream FIFO, trace freeze,
// ring wrap and mid-operation reset.
module tb_trace_mem_ctrl;
   import trace_mem_pkg::*;

   localparam int W = 32;
   localparam int D = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   trg_mode_t     mode;
   logic [5:0]    post_words;
   logic          store;
   logic [W-1:0]  data;
   logic          store_perm;
   logic          load_req;
   logic          grant;
   logic [W-1:0]  dout;
   logic          trg;
   logic [4:0]    evt_pos;
   logic          trg_dly;
   logic [5:0]    trg_addr;
   logic [4:0]    evt_pos_o;
   logic [6:0]    count;

   logic [W-1:0] exp_q [$];
   int n_chk = 0;
   int n_err = 0;
   int n_gnt = 0;
   int g0;

   always #5 clk = ~clk;

   trace_mem_ctrl #(.TRB_WIDTH(W), .TRB_DEPTH(D)) dut (
      .FPGA_CLK_I     (clk),
      .RST_I          (rst_n),
      .MODE_I         (mode),
      .POST_WORDS_I   (post_words),
      .STORE_I        (store),
      .DATA_I         (data),
      .STORE_PERM_O   (store_perm),
      .LOAD_REQUEST_I (load_req),
      .LOAD_GRANT_O   (grant),
      .DATA_O         (dout),
      .TRG_EVENT_I    (trg),
      .EVENT_POS_I    (evt_pos),
      .TRG_DELAYED_O  (trg_dly),
      .TRG_ADDR_O     (trg_addr),
      .EVENT_POS_O    (evt_pos_o),
      .COUNT_O        (count)
   );

   task automatic chk(input string tag,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Every grant is scored against the scoreboard queue
   task automatic tick();
      @(posedge clk);
      #1;
      if (grant) begin
         n_gnt++;
         if (exp_q.size() == 0) chk("spurious_grant", 32'(grant), 32'd0);
         else chk("grant_data", dout, exp_q.pop_front());
      end
   endtask

   task automatic do_reset(input trg_mode_t m, input logic [5:0] p);
      rst_n = 1'b0;
      store = 1'b0;
      load_req = 1'b0;
      trg = 1'b0;
      mode = m;
      post_words = p;
      tick();
      tick();
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic st(input logic [W-1:0] d);
      store = 1'b1;
      data = d;
      tick();
      store = 1'b0;
   endtask

   task automatic drain(input string tag, input int maxc);
      load_req = 1'b1;
      for (int i = 0; i < maxc && exp_q.size() != 0; i++) tick();
      load_req = 1'b0;
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      store = 1'b0;
      data = '0;
      load_req = 1'b0;
      trg = 1'b0;
      evt_pos = '0;
      mode = w_stream_mode;
      post_words = '0;

      // FIFO basic
      do_reset(w_stream_mode, 6'd0);
      tick();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_perm", 32'(store_perm), 32'd1);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_dout", dout, 32'd0);
      chk("rst_trg_dly", 32'(trg_dly), 32'd0);
      chk("rst_trg_addr", 32'(trg_addr), 32'd0);
      chk("rst_evt_pos", 32'(evt_pos_o), 32'd0);
      st(32'h1111_1111); exp_q.push_back(32'h1111_1111);
      st(32'h2222_2222); exp_q.push_back(32'h2222_2222);
      chk("basic_count2", 32'(count), 32'd2);
      load_req = 1'b1;
      tick();
      chk("basic_gnt_lat", 32'(grant), 32'd1);
      drain("basic", 10);
      tick();
      chk("basic_count0", 32'(count), 32'd0);

      // FIFO full
      do_reset(w_stream_mode, 6'd0);
      for (int i = 0; i < D; i++) begin
         st(32'hA000_0000 + 32'(i));
         exp_q.push_back(32'hA000_0000 + 32'(i));
      end
      chk("full_count", 32'(count), 32'(D));
      chk("full_perm", 32'(store_perm), 32'd0);
      st(32'hDEAD_BEEF);
      chk("full_drop_count", 32'(count), 32'(D));
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      chk("full_one_gnt", 32'(grant), 32'd1);
      chk("full_perm_back", 32'(store_perm), 32'd1);
      drain("full", 200);

      // Request while empty
      do_reset(r_stream_mode, 6'd0);
      load_req = 1'b1;
      g0 = n_gnt;
      repeat (3) tick();
      chk("empty_no_gnt", 32'(n_gnt - g0), 32'd0);
      st(32'hABCD_1234); exp_q.push_back(32'hABCD_1234);
      chk("empty_t1_gnt", 32'(grant), 32'd0);
      tick();
      chk("empty_t2_gnt", 32'(grant), 32'd1);
      load_req = 1'b0;
      tick();

      // Trace freeze
      do_reset(trace_mode, 6'd3);
      for (int i = 1; i <= 3; i++) st(32'h100 + 32'(i));
      trg = 1'b1;
      evt_pos = 5'd5;
      tick();
      trg = 1'b0;
      chk("frz_trg_addr", 32'(trg_addr), 32'd3);
      chk("frz_evt_pos", 32'(evt_pos_o), 32'd5);
      for (int i = 4; i <= 5; i++) st(32'h100 + 32'(i));
      trg = 1'b1;
      evt_pos = 5'd7;
      tick();
      trg = 1'b0;
      chk("frz_ign_evt", 32'(evt_pos_o), 32'd5);
      chk("frz_ign_addr", 32'(trg_addr), 32'd3);
      st(32'h106);
      chk("frz_dly_early", 32'(trg_dly), 32'd0);
      st(32'h107);
      chk("frz_dly_rise", 32'(trg_dly), 32'd1);
      chk("frz_perm", 32'(store_perm), 32'd0);
      for (int i = 8; i <= 10; i++) st(32'h100 + 32'(i));
      chk("frz_count", 32'(count), 32'd7);
      for (int i = 1; i <= 7; i++) exp_q.push_back(32'h100 + 32'(i));
      drain("frz", 40);
      tick();
      chk("frz_dly_sticky", 32'(trg_dly), 32'd1);

      // Trace wrap
      do_reset(trace_mode, 6'd0);
      for (int i = 1; i <= D + 5; i++) st(32'(i));
      chk("wrap_count_sat", 32'(count), 32'(D));
      trg = 1'b1;
      evt_pos = 5'd31;
      tick();
      trg = 1'b0;
      chk("wrap_trg_addr", 32'(trg_addr), 32'd5);
      st(32'(D + 6));
      chk("wrap_dly", 32'(trg_dly), 32'd1);
      for (int i = 7; i <= D + 6; i++) exp_q.push_back(32'(i));
      drain("wrap", 200);
      g0 = n_gnt;
      load_req = 1'b1;
      repeat (10) tick();
      load_req = 1'b0;
      chk("wrap_no_more", 32'(n_gnt - g0), 32'd0);

      // Mid-operation reset
      do_reset(trace_mode, 6'd5);
      st(32'h5001);
      st(32'h5002);
      trg = 1'b1;
      evt_pos = 5'd9;
      tick();
      trg = 1'b0;
      st(32'h5003);
      chk("mid_pre_addr", 32'(trg_addr), 32'd2);
      load_req = 1'b1;
      rst_n = 1'b0;
      tick();
      chk("mid_count", 32'(count), 32'd0);
      chk("mid_trg_addr", 32'(trg_addr), 32'd0);
      chk("mid_evt_pos", 32'(evt_pos_o), 32'd0);
      chk("mid_trg_dly", 32'(trg_dly), 32'd0);
      chk("mid_grant", 32'(grant), 32'd0);
      chk("mid_dout", dout, 32'd0);
      rst_n = 1'b1;
      load_req = 1'b0;
      tick();
      tick();
      chk("mid_perm", 32'(store_perm), 32'd1);
      chk("mid_count_rel", 32'(count), 32'd0);
      post_words = 6'd0;
      st(32'h6001);
      st(32'h6002);
      store = 1'b1;
      data = 32'h6003;
      trg = 1'b1;
      evt_pos = 5'd3;
      tick();
      store = 1'b0;
      trg = 1'b0;
      chk("mid_new_addr", 32'(trg_addr), 32'd2);
      chk("mid_new_evt", 32'(evt_pos_o), 32'd3);
      chk("mid_same_cyc_frz", 32'(trg_dly), 32'd1);
      exp_q.push_back(32'h6001);
      exp_q.push_back(32'h6002);
      exp_q.push_back(32'h6003);
      drain("mid", 20);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/trace_mem_ctrl.md
TRACE_MEM_CTRL -- requirements
Module: trace_mem_ctrl

Interface
REQ-001 SHALL have parameter TRB_WIDTH, default 32, meaning the memory word width in bits; it equals the Tracer word width.
REQ-002 SHALL have parameter TRB_DEPTH, default 64, meaning the number of words (power of two, >=2); pointers are $clog2(TRB_DEPTH) bits wide.
REQ-003 SHALL have ports:
- FPGA_CLK_I  in  1  sole clock; all logic on rising edge.
- RST_I  in  1  synchronous, active-low reset.
- MODE_I  in  trg_mode_t  trace_mode / w_stream_mode / r_stream_mode.
- POST_WORDS_I  in  $clog2(TRB_DEPTH)  words stored after the trigger word before freeze.
- STORE_I  in  1  single-cycle store strobe from Tracer.
- DATA_I  in  TRB_WIDTH  store data.
- STORE_PERM_O  out  1  store permission to Tracer.
- LOAD_REQUEST_I  in  1  level load request from Tracer.
- LOAD_GRANT_O  out  1  single-cycle grant; DATA_O is valid in the same cycle.
- DATA_O  out  TRB_WIDTH  load data.
- TRG_EVENT_I  in  1  trigger event from Tracer.
- EVENT_POS_I  in  $clog2(TRB_WIDTH)  bit position of the event.
- TRG_DELAYED_O  out  1  post-trigger window complete (sticky).
- TRG_ADDR_O  out  $clog2(TRB_DEPTH)  word address that holds the trigger.
- EVENT_POS_O  out  $clog2(TRB_WIDTH)  latched EVENT_POS_I.
- COUNT_O  out  $clog2(TRB_DEPTH)+1  words currently held.

Function
REQ-004 Storage SHALL be a TRB_DEPTH-word ring with write pointer wr_ptr, read pointer rd_ptr and occupancy count; both pointers wrap from TRB_DEPTH-1 to 0.
REQ-005 A store SHALL be accepted iff STORE_I=1 and STORE_PERM_O=1 in the same cycle: mem[wr_ptr]<=DATA_I, then wr_ptr+1. STORE_I while STORE_PERM_O=0 SHALL be dropped with no state change.
REQ-006 Load handshake:
- A grant SHALL issue the cycle after LOAD_REQUEST_I=1 is sampled, provided the registered count>0, loads are allowed in the current state, and LOAD_GRANT_O=0 in the sampling cycle.
- A grant cycle SHALL present DATA_O=mem[rd_ptr] and advance rd_ptr by one.
- DATA_O SHALL hold its last value otherwise.
- A request made while count=0 SHALL stay pending until data exists; this does not count as a protocol error.
REQ-007 The count SHALL be +1 on an accepted store, -1 on a grant, and unchanged when both occur in the same cycle.
REQ-008 In stream modes (w_stream_mode, r_stream_mode) the block SHALL act as a FIFO: STORE_PERM_O=(count<TRB_DEPTH); loads are always allowed; state is STREAM.
REQ-009 trace_mode FSM states:
- ARMED: STORE_PERM_O=1; loads blocked. When full, a store SHALL overwrite the oldest word: rd_ptr advances and count saturates at TRB_DEPTH.
- POST: same store rule as ARMED; post counter pc counts accepted stores.
- FROZEN: STORE_PERM_O=0; loads allowed from oldest to newest word.
REQ-010 ARMED->POST SHALL occur on the first cycle with TRG_EVENT_I=1. In that cycle the block SHALL latch TRG_ADDR_O<=wr_ptr and EVENT_POS_O<=EVENT_POS_I, and set pc<=0.
REQ-011 POST->FROZEN SHALL occur on the accepted store that makes pc=POST_WORDS_I+1 (trigger word plus POST_WORDS_I words). TRG_DELAYED_O SHALL rise the next cycle and stay at 1 until reset.
REQ-012 A store and TRG_EVENT_I in the same ARMED cycle SHALL latch TRG_ADDR_O as the pre-increment wr_ptr and count that store toward pc.
REQ-013 TRG_EVENT_I in POST or FROZEN SHALL be ignored; trigger latches are written once per reset.
REQ-014 A MODE_I change without reset is unsupported; behaviour is undefined.

Reset
REQ-015 When RST_I=0 at a rising edge, the block SHALL clear wr_ptr, rd_ptr, count, pc, TRG_ADDR_O, EVENT_POS_O, TRG_DELAYED_O, LOAD_GRANT_O and DATA_O to 0. Memory contents are not cleared.
REQ-016 After reset the state SHALL be ARMED in trace_mode and STREAM otherwise. STORE_PERM_O SHALL be 1 from the first cycle after reset release.
REQ-017 Reset mid-operation SHALL discard pending requests, and no grant SHALL follow reset release unless a new request is sampled.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- FIFO basic, w_stream_mode: store 0x11111111, 0x22222222 -> COUNT_O=2; request -> grant next cycle with DATA_O=0x11111111, then 0x22222222; COUNT_O=0.
- FIFO full: DEPTH stores, then a 65th store -> STORE_PERM_O=0 and the 65th is dropped; one grant -> STORE_PERM_O=1.
- Empty request: request held at count=0; store at cycle t -> grant at t+2 with the stored data.
- Trace freeze: POST_WORDS_I=3; 10 stores; TRG_EVENT_I with EVENT_POS_I=5 before store 4 -> TRG_ADDR_O=3, EVENT_POS_O=5; TRG_DELAYED_O rises one cycle after store 7; STORE_PERM_O=0; 8th store dropped.
- Trace wrap: DEPTH+5 stores before trigger, POST_WORDS_I=0 -> readout yields DEPTH words starting with store #7 (1-based), in order; then no further grants.
- Mid-operation reset: assert RST_I=0 during POST -> all outputs 0, ARMED, COUNT_O=0; a new trigger is accepted.
